// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage sequencer: op codes, FSM states, byte enables.
package mem_pkg;

    // Operation field carried in the EX/MEM buffer
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_SB  = 2'b11;

    // Byte enables on the data-memory port; bit1 selects the high byte
    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_LO   = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

endpackage

// File: rtl/busy_timer.sv
// 8-bit cycle counter for the BUSY state; tc flags the last permitted wait cycle.
module busy_timer #(
    parameter int unsigned TMO = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] cnt_q, cnt_d;

    // Next count: clear has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count starts at 0 in the first BUSY cycle, so TMO-1 marks the TMO-th cycle
    assign tc = (cnt_q == 8'(TMO - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: one req/ack transaction per EX/MEM op, stalling the pipe meanwhile.
module mem_access_ctrl #(
    parameter int unsigned S   = 15,
    parameter int unsigned TMO = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ex_valid,
    input  logic [1:0]   ex_ctrl,
    input  logic [S:0]   ex_addr,
    input  logic [S:0]   ex_word,
    input  logic [7:0]   ex_byte,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [1:0]   mem_be,
    output logic [S:0]   mem_addr,
    output logic [S:0]   mem_wdata,
    input  logic         mem_ack,
    input  logic [S:0]   mem_rdata,
    output logic         wb_valid,
    output logic [S:0]   wb_data,
    output logic         err
);

    import mem_pkg::*;

    localparam int unsigned W = S + 1;

    state_e       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic         mem_req_q, mem_req_d;
    logic         mem_we_q, mem_we_d;
    logic [1:0]   mem_be_q, mem_be_d;
    logic [S:0]   mem_addr_q, mem_addr_d;
    logic [S:0]   mem_wdata_q, mem_wdata_d;
    logic         wb_valid_q, wb_valid_d;
    logic [S:0]   wb_data_q, wb_data_d;
    logic         err_q, err_d;
    logic         stall_c;
    logic         timer_clr, timer_en, timer_tc;

    busy_timer #(
        .TMO (TMO)
    ) u_busy_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .en  (timer_en),
        .tc  (timer_tc)
    );

    // Next-state, latched operands and combinational stall
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_data_d   = wb_data_q;
        wb_valid_d  = 1'b0;
        err_d       = 1'b0;
        stall_c     = 1'b0;
        timer_clr   = 1'b1;
        timer_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ex_valid && (ex_ctrl != OP_NOP)) begin
                    stall_c    = 1'b1;
                    op_d       = ex_ctrl;
                    mem_addr_d = {ex_addr[S:1], 1'b0};
                    if ((ex_ctrl != OP_SB) && ex_addr[0]) begin
                        // Misaligned word access never reaches the memory port
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = BUSY;
                        mem_req_d = 1'b1;
                        mem_we_d  = (ex_ctrl != OP_LW);
                        if (ex_ctrl == OP_SB) begin
                            mem_be_d    = ex_addr[0] ? BE_HI : BE_LO;
                            mem_wdata_d = W'({ex_byte, ex_byte});
                        end else begin
                            mem_be_d    = BE_WORD;
                            mem_wdata_d = ex_word;
                        end
                    end
                end
            end
            BUSY: begin
                stall_c   = 1'b1;
                timer_clr = 1'b0;
                if (mem_ack) begin
                    // Ack wins over a coincident terminal count
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (op_q == OP_LW) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = mem_rdata;
                    end
                end else if (timer_tc) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    timer_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_NOP;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
        end
    end

    // State is forced to IDLE in reset, so gate stall explicitly to keep it low then
    assign stall     = stall_c & ~rst;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, random transactions, reset cases.
module tb_mem_access_ctrl;

    import mem_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [1:0]  ex_ctrl;
    logic [15:0] ex_addr, ex_word;
    logic [7:0]  ex_byte;
    logic        stall, mem_req, mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] model_wbd;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .S   (15),
        .TMO (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .ex_ctrl   (ex_ctrl),
        .ex_addr   (ex_addr),
        .ex_word   (ex_word),
        .ex_byte   (ex_byte),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .err       (err)
    );

    // One transaction: stimulus plus expected behaviour.
    // ack_at: BUSY cycle (1-based) carrying the ack, 0 = never.
    // req_cycles: cycles mem_req must stay high; wbd: wb_data after DONE.
    typedef struct {
        logic        valid;
        logic [1:0]  ctrl;
        logic [15:0] addr;
        logic [15:0] word;
        logic [7:0]  byt;
        int          ack_at;
        logic [15:0] rdata;
        int          req_cycles;
        logic        we;
        logic [1:0]  be;
        logic [15:0] maddr;
        logic [15:0] wdata;
        logic        wbv;
        logic        err;
        logic [15:0] wbd;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        check(name, {15'd0, act}, {15'd0, exp});
    endtask

    function automatic vec_t mk(input logic valid, input logic [1:0] ctrl, input logic [15:0] addr,
                                input logic [15:0] word, input logic [7:0] byt, input int ack_at,
                                input logic [15:0] rdata, input int req_cycles, input logic we,
                                input logic [1:0] be, input logic [15:0] maddr,
                                input logic [15:0] wdata, input logic wbv, input logic e,
                                input logic [15:0] wbd);
        vec_t v;
        v.valid = valid; v.ctrl = ctrl; v.addr = addr; v.word = word; v.byt = byt;
        v.ack_at = ack_at; v.rdata = rdata; v.req_cycles = req_cycles; v.we = we; v.be = be;
        v.maddr = maddr; v.wdata = wdata; v.wbv = wbv; v.err = e; v.wbd = wbd;
        return v;
    endfunction

    // Reference: derive the transaction outcome straight from the op rules
    function automatic vec_t model_vec();
        vec_t v;
        logic active, mis;
        v.valid  = ($urandom_range(0, 7) != 0);
        v.ctrl   = 2'($urandom);
        v.addr   = 16'($urandom);
        v.word   = 16'($urandom);
        v.byt    = 8'($urandom);
        v.rdata  = 16'($urandom);
        v.ack_at = $urandom_range(0, TMO);
        v.req_cycles = 0; v.we = 1'b0; v.be = 2'b00; v.maddr = 16'h0; v.wdata = 16'h0;
        v.wbv = 1'b0; v.err = 1'b0; v.wbd = model_wbd;
        active = v.valid && (v.ctrl != OP_NOP);
        mis    = active && (v.ctrl != OP_SB) && v.addr[0];
        if (mis) begin
            v.err = 1'b1;
        end else if (active) begin
            v.req_cycles = (v.ack_at == 0) ? TMO : v.ack_at;
            v.err   = (v.ack_at == 0);
            v.wbv   = (v.ctrl == OP_LW) && (v.ack_at != 0);
            if (v.wbv) v.wbd = v.rdata;
            v.we    = (v.ctrl != OP_LW);
            v.be    = (v.ctrl == OP_SB) ? (v.addr[0] ? 2'b10 : 2'b01) : 2'b11;
            v.maddr = v.addr & 16'hFFFE;
            v.wdata = (v.ctrl == OP_SW) ? v.word : {v.byt, v.byt};
        end
        return v;
    endfunction

    task automatic scramble();
        ex_valid = 1'($urandom);
        ex_ctrl  = 2'($urandom);
        ex_addr  = 16'($urandom);
        ex_word  = 16'($urandom);
        ex_byte  = 8'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        ex_valid = v.valid; ex_ctrl = v.ctrl; ex_addr = v.addr;
        ex_word = v.word; ex_byte = v.byt;
        mem_ack = 1'($urandom);
        mem_rdata = 16'($urandom);
        #1;
        check_b($sformatf("%s stall_issue", tag), stall, v.valid && (v.ctrl != OP_NOP));
        check_b($sformatf("%s req_issue", tag), mem_req, 1'b0);
        check_b($sformatf("%s wbv_issue", tag), wb_valid, 1'b0);
        check_b($sformatf("%s err_issue", tag), err, 1'b0);
        check($sformatf("%s wbd_issue", tag), wb_data, model_wbd);
        if (v.req_cycles == 0 && !v.err) return;
        for (int i = 1; i <= v.req_cycles; i++) begin
            @(negedge clk);
            scramble();
            mem_ack   = (v.ack_at == i);
            mem_rdata = mem_ack ? v.rdata : 16'($urandom);
            #1;
            check_b($sformatf("%s stall_busy%0d", tag, i), stall, 1'b1);
            check_b($sformatf("%s req_busy%0d", tag, i), mem_req, 1'b1);
            check_b($sformatf("%s we_busy%0d", tag, i), mem_we, v.we);
            check($sformatf("%s be_busy%0d", tag, i), {14'd0, mem_be}, {14'd0, v.be});
            check($sformatf("%s addr_busy%0d", tag, i), mem_addr, v.maddr);
            if (v.ctrl != OP_LW)
                check($sformatf("%s wdata_busy%0d", tag, i), mem_wdata, v.wdata);
            check_b($sformatf("%s wbv_busy%0d", tag, i), wb_valid, 1'b0);
            check_b($sformatf("%s err_busy%0d", tag, i), err, 1'b0);
        end
        @(negedge clk);
        scramble();
        mem_ack   = 1'($urandom);
        mem_rdata = 16'($urandom);
        #1;
        check_b($sformatf("%s stall_done", tag), stall, 1'b0);
        check_b($sformatf("%s req_done", tag), mem_req, 1'b0);
        check_b($sformatf("%s wbv_done", tag), wb_valid, v.wbv);
        check_b($sformatf("%s err_done", tag), err, v.err);
        check($sformatf("%s wbd_done", tag), wb_data, v.wbd);
        model_wbd = v.wbd;
    endtask

    initial begin
        //            vld ctrl   addr      word      byte  ack rdata     req we be     maddr     wdata     wbv err wbd
        tbl[0] = mk(1, OP_LW, 16'h0040, 16'h0000, 8'h00, 2, 16'hBEEF, 2, 0, 2'b11, 16'h0040, 16'h0000, 1, 0, 16'hBEEF);
        tbl[1] = mk(1, OP_SB, 16'h0013, 16'h0000, 8'hA5, 1, 16'h0000, 1, 1, 2'b10, 16'h0012, 16'hA5A5, 0, 0, 16'hBEEF);
        tbl[2] = mk(1, OP_SW, 16'h0021, 16'h7777, 8'h00, 1, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'hBEEF);
        tbl[3] = mk(1, OP_LW, 16'h0100, 16'h0000, 8'h00, 0, 16'h0000, 4, 0, 2'b11, 16'h0100, 16'h0000, 0, 1, 16'hBEEF);
        tbl[4] = mk(1, OP_SW, 16'h0022, 16'h1234, 8'h00, 4, 16'h0000, 4, 1, 2'b11, 16'h0022, 16'h1234, 0, 0, 16'hBEEF);
        tbl[5] = mk(1, OP_NOP, 16'h0031, 16'h0000, 8'h00, 1, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 16'hBEEF);
        tbl[6] = mk(0, OP_LW, 16'h0032, 16'h0000, 8'h00, 1, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0, 16'hBEEF);
        tbl[7] = mk(1, OP_SB, 16'h0014, 16'h0000, 8'h3C, 3, 16'h0000, 3, 1, 2'b01, 16'h0014, 16'h3C3C, 0, 0, 16'hBEEF);
        tbl[8] = mk(1, OP_LW, 16'h0007, 16'h0000, 8'h00, 1, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 1, 16'hBEEF);
        tbl[9] = mk(1, OP_LW, 16'h8002, 16'h0000, 8'h00, 1, 16'h1357, 1, 0, 2'b11, 16'h8002, 16'h0000, 1, 0, 16'h1357);

        // Reset with a live op presented: stall must stay low, all outputs cleared
        rst = 1'b1; ex_valid = 1'b1; ex_ctrl = OP_LW; ex_addr = 16'h0040;
        ex_word = 16'h0; ex_byte = 8'h0; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        model_wbd = 16'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_b("reset stall", stall, 1'b0);
        check_b("reset req", mem_req, 1'b0);
        check_b("reset we", mem_we, 1'b0);
        check("reset be", {14'd0, mem_be}, 16'h0);
        check("reset addr", mem_addr, 16'h0);
        check("reset wdata", mem_wdata, 16'h0);
        check_b("reset wbv", wb_valid, 1'b0);
        check("reset wbd", wb_data, 16'h0);
        check_b("reset err", err, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0; mem_ack = 1'b0; rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 200; i++) run_vec(model_vec(), $sformatf("rnd%0d", i));

        // Make wb_data non-zero, then reset in the middle of a load
        run_vec(mk(1, OP_LW, 16'h0010, 16'h0, 8'h0, 1, 16'h5A5A, 1, 0, 2'b11, 16'h0010, 16'h0,
                   1, 0, 16'h5A5A), "preload");
        @(negedge clk);
        ex_valid = 1'b1; ex_ctrl = OP_LW; ex_addr = 16'h0200; mem_ack = 1'b0;
        @(negedge clk);
        #1;
        check_b("midrst req_before", mem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_b("midrst req", mem_req, 1'b0);
        check_b("midrst stall", stall, 1'b0);
        check("midrst wbd", wb_data, 16'h0);
        @(negedge clk);
        rst = 1'b0; ex_valid = 1'b1; ex_ctrl = OP_NOP;
        #1;
        check_b("post_rst nop stall", stall, 1'b0);
        check_b("post_rst nop req", mem_req, 1'b0);
        @(negedge clk);
        #1;
        check_b("post_rst nop stall2", stall, 1'b0);
        check_b("post_rst nop req2", mem_req, 1'b0);
        check_b("post_rst nop wbv", wb_valid, 1'b0);
        model_wbd = 16'h0;

        run_vec(mk(1, OP_LW, 16'h0010, 16'h0, 8'h0, 2, 16'hCAFE, 2, 0, 2'b11, 16'h0010, 16'h0,
                   1, 0, 16'hCAFE), "post_rst_lw");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the memory stage of the 16-bit pipeline. It sits after the EX/MEM pipeline buffer and turns the buffered control field and operands into a single request/acknowledge transaction on the data-memory port. It holds the pipeline with `stall` until the access completes, times out, or is rejected as misaligned. It then presents load data toward MEM/WB.

## Interface
- `S`, default 15: MSB index of address and data words (16-bit datapath).
- `TMO`, default 15: maximum BUSY cycles to wait for `mem_ack` before abort; legal range 1..255.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ex_valid`  in  1: EX/MEM buffer holds a live instruction.
- `ex_ctrl`  in  2: operation. 00 = NOP, 01 = LW, 10 = SW, 11 = SB.
- `ex_addr`  in  S+1: byte address, taken from the ALU lower result.
- `ex_word`  in  S+1: store data for SW.
- `ex_byte`  in  8: store data for SB.
- `stall`  out  1: freeze the EX/MEM buffer and all upstream stages.
- `mem_req`  out  1: memory request; registered.
- `mem_we`  out  1: write enable; valid while `mem_req`=1.
- `mem_be`  out  2: byte enables; bit1 = high byte.
- `mem_addr`  out  S+1: word-aligned address, i.e. `ex_addr` with bit0 cleared.
- `mem_wdata`  out  S+1: write data.
- `mem_ack`  in  1: memory completion; single-cycle pulse.
- `mem_rdata`  in  S+1: read data; valid when `mem_ack`=1.
- `wb_valid`  out  1: one-cycle pulse, load data valid.
- `wb_data`  out  S+1: load result; holds its value until the next load completes.
- `err`  out  1: one-cycle pulse on timeout or misaligned word access.

## Operation
- State machine has three states: IDLE, BUSY, DONE.
- **IDLE**
  - `stall` = `ex_valid` & (`ex_ctrl` != NOP). This is combinational, so the buffer holds in the same cycle the op is presented.
  - A NOP, or `ex_valid`=0, causes no action.
  - On a non-NOP op, latch the operation, address and data, then go to BUSY. Exception: an LW or SW with `ex_addr[0]`=1 skips BUSY and goes straight to DONE with the error flagged.
- **BUSY**
  - Outputs: `stall`=1 and `mem_req`=1. `mem_we`=1 for SW and SB.
  - SW: `mem_be`=11, `mem_wdata`=`ex_word`.
  - SB: `mem_be` = 10 if `ex_addr[0]`, otherwise 01. `mem_wdata` = {`ex_byte`,`ex_byte`}.
  - LW: `mem_be`=11, `mem_we`=0.
  - On `mem_ack`=1, capture `mem_rdata` (LW only) and go to DONE.
  - The timeout counter increments each BUSY cycle without an ack. When it reaches `TMO`, go to DONE with the error flagged.
- **DONE**
  - `stall`=0 and `mem_req`=0.
  - `wb_valid`=1 only for an LW that received its ack.
  - `err`=1 if the access was aborted or misaligned.
  - The `ex_*` inputs are ignored in DONE: the old instruction is still visible in the buffer during this cycle.
  - Next state is always IDLE.
- Aborted LW: `wb_valid`=0 and `wb_data` unchanged.
- `mem_ack` outside BUSY is ignored. Changes on `ex_*` during BUSY are ignored because operands are latched.
- Misaligned SB is legal; only word accesses require an even address.

## Timing
- Reset values: state IDLE, counter 0. Outputs `mem_req`, `mem_we`, `wb_valid`, `err` = 0. Outputs `mem_be`, `mem_addr`, `mem_wdata`, `wb_data` = 0.
  - `stall` = 0 during reset regardless of inputs.
- Reset mid-BUSY drops `mem_req` asynchronously and abandons the access. The memory side must tolerate this.
- Latency for an op first seen at cycle t:
  - `mem_req` goes high at t+1.
  - An ack at cycle t+k (k≥1) gives DONE at t+k+1, with `stall` low in that cycle.
  - Minimum cost is 3 cycles per memory op.
- Misaligned word access: DONE at t+1 with the `err` pulse; no `mem_req` is issued.
- Timeout: with no ack, `mem_req` stays high for exactly `TMO` cycles, then DONE follows.
- An ack in the same cycle as the timeout terminal count takes priority: normal completion, no `err`.
- `stall` is the only combinational output. All memory-port outputs come directly from registers.

## Structure
- Shared package `mem_pkg` holds:
  - Op codes `OP_NOP`, `OP_LW`, `OP_SW`, `OP_SB`.
  - State enum `IDLE`, `BUSY`, `DONE`.
  - Byte-enable constants `BE_WORD`=11, `BE_HI`=10, `BE_LO`=01.
- One natural sub-module, `busy_timer`: 8-bit counter with clear, enable and terminal-count output compared against `TMO`.

## Test plan
- **Load:** after reset, LW at address 0x0040 with `mem_ack` two cycles after `mem_req` and `mem_rdata`=0xBEEF. Expect `stall` high for 3 cycles, then `wb_valid` pulse with `wb_data`=0xBEEF; `err`=0.
- **Byte store:** SB at address 0x0013 with `ex_byte`=0xA5. Expect `mem_addr`=0x0012, `mem_be`=10, `mem_wdata`=0xA5A5, `mem_we`=1, no `wb_valid`.
- **Misaligned word:** SW at address 0x0021. Expect no `mem_req`, an `err` pulse at t+1, and `stall` high only in cycle t.
- **Timeout:** `TMO`=4 and `mem_ack` never asserted. Expect `mem_req` high for exactly 4 cycles, then an `err` pulse; `wb_data` keeps its previous value.
- **Ack/timeout collision:** ack arrives on the terminal-count cycle. Expect normal completion and no `err`.
- **Reset during BUSY:** assert `rst` mid-BUSY. Expect `mem_req`, `stall` and `wb_data` to go to 0 immediately; after release, a NOP with `ex_valid`=1 leaves `stall`=0.
